intwb_arbiter: RTL and testbench

INTWB_ARBITER -- requirements
Module: intwb_arbiter

---
 rtl/intwb_arbiter.sv | 158 +++++++++++++++
 tb/tb_intwb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intwb_arbiter.sv
// Integer register-file write-port arbiter: Writeback pipeline vs. MDU/DIV units.
// Optional starvation guard enabled by defining INTWB_STARVE_GUARD_EN.
module intwb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PipeValidW,
  input  logic [4:0]      PipeRdW,
  input  logic [XLEN-1:0] PipeResultW,
  input  logic            MduValid,
  input  logic [4:0]      MduRd,
  input  logic [XLEN-1:0] MduResult,
  output logic            MduReady,
  input  logic            DivValid,
  input  logic [4:0]      DivRd,
  input  logic [XLEN-1:0] DivResult,
  output logic            DivReady,
  input  logic            IssueValidE,
  input  logic [4:0]      IssueRdE,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  output logic            BusyRs1D,
  output logic            BusyRs2D,
  output logic            RegWriteO,
  output logic [4:0]      RdO,
  output logic [XLEN-1:0] ResultO,
  output logic            StallPipe
);

  logic        last_q;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        pipe_own;
  logic        gnt_mdu;
  logic        gnt_div;
  logic        unit_gnt;
  logic        any_valid;
  logic [4:0]  gnt_rd;

  assign any_valid = MduValid | DivValid;
  assign unit_gnt  = gnt_mdu | gnt_div;
  assign gnt_rd    = gnt_mdu ? MduRd : DivRd;

  // Ownership: forced unit slot, then pipeline, then round-robin units
  always_comb begin
    pipe_own = 1'b0;
    gnt_mdu  = 1'b0;
    gnt_div  = 1'b0;
    if (!reset) begin
      pipe_own = !StallPipe && PipeValidW && (PipeRdW != 5'd0);
      if (!pipe_own) begin
        if (MduValid && DivValid) begin
          gnt_mdu = last_q;
          gnt_div = !last_q;
        end else begin
          gnt_mdu = MduValid;
          gnt_div = DivValid;
        end
      end
    end
  end

  assign MduReady = gnt_mdu;
  assign DivReady = gnt_div;

  // Drive the register-file write port from the granted source
  always_comb begin
    RegWriteO = 1'b0;
    RdO       = 5'd0;
    ResultO   = '0;
    unique case (1'b1)
      pipe_own: begin
        RegWriteO = 1'b1;
        RdO       = PipeRdW;
        ResultO   = PipeResultW;
      end
      gnt_mdu: begin
        RegWriteO = MduRd != 5'd0;
        RdO       = MduRd;
        ResultO   = MduResult;
      end
      gnt_div: begin
        RegWriteO = DivRd != 5'd0;
        RdO       = DivRd;
        ResultO   = DivResult;
      end
      default: ;
    endcase
  end

  // Scoreboard next state: clear on grant, then set on issue (set wins)
  always_comb begin
    busy_d = busy_q;
    if (unit_gnt && gnt_rd != 5'd0)
      busy_d[gnt_rd] = 1'b0;
    if (IssueValidE && IssueRdE != 5'd0)
      busy_d[IssueRdE] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign BusyRs1D = busy_q[Rs1D];
  assign BusyRs2D = busy_q[Rs2D];

  // Scoreboard and round-robin state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      last_q <= 1'b1;
    end else begin
      busy_q <= busy_d;
      if (unit_gnt)
        last_q <= gnt_div;
    end
  end

`ifdef INTWB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       stall_q;
  logic       stall_d;

  // Count cycles the pipeline keeps a waiting unit off the port
  always_comb begin
    cnt_d   = cnt_q;
    stall_d = stall_q;
    if (unit_gnt || !any_valid)
      cnt_d = 4'd0;
    else if (pipe_own)
      cnt_d = cnt_q + 4'd1;
    if (stall_q) begin
      if (unit_gnt || !any_valid)
        stall_d = 1'b0;
    end else if (cnt_d == LIMIT) begin
      stall_d = 1'b1;
    end
  end

  // Starvation counter and registered stall request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign StallPipe = stall_q;
`else
  assign StallPipe = 1'b0;
`endif

endmodule

// File: tb/tb_intwb_arbiter.sv
// Directed bench for intwb_arbiter: expected writes are queued by stimulus
// and popped by a negedge monitor whenever the write port fires.
module tb_intwb_arbiter;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            PipeValidW;
  logic [4:0]      PipeRdW;
  logic [XLEN-1:0] PipeResultW;
  logic            MduValid;
  logic [4:0]      MduRd;
  logic [XLEN-1:0] MduResult;
  logic            MduReady;
  logic            DivValid;
  logic [4:0]      DivRd;
  logic [XLEN-1:0] DivResult;
  logic            DivReady;
  logic            IssueValidE;
  logic [4:0]      IssueRdE;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic            BusyRs1D;
  logic            BusyRs2D;
  logic            RegWriteO;
  logic [4:0]      RdO;
  logic [XLEN-1:0] ResultO;
  logic            StallPipe;

  intwb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .PipeValidW(PipeValidW),
    .PipeRdW(PipeRdW),
    .PipeResultW(PipeResultW),
    .MduValid(MduValid),
    .MduRd(MduRd),
    .MduResult(MduResult),
    .MduReady(MduReady),
    .DivValid(DivValid),
    .DivRd(DivRd),
    .DivResult(DivResult),
    .DivReady(DivReady),
    .IssueValidE(IssueValidE),
    .IssueRdE(IssueRdE),
    .Rs1D(Rs1D),
    .Rs2D(Rs2D),
    .BusyRs1D(BusyRs1D),
    .BusyRs2D(BusyRs2D),
    .RegWriteO(RegWriteO),
    .RdO(RdO),
    .ResultO(ResultO),
    .StallPipe(StallPipe)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
  } wr_t;

  wr_t expq[$];
  int  tests = 0;
  int  fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [4:0] rd, input logic [XLEN-1:0] res);
    wr_t w;
    w.rd  = rd;
    w.res = res;
    expq.push_back(w);
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Monitor: every write-port event must match the oldest expected write
  always @(negedge clk) begin : mon
    wr_t e;
    if (RegWriteO === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got rd=%0d res=%0h expected no write",
                 RdO, ResultO);
      end else begin
        e = expq.pop_front();
        if (RdO !== e.rd || ResultO !== e.res) begin
          fails++;
          $display("FAIL wr_data: got rd=%0d res=%0h expected rd=%0d res=%0h",
                   RdO, ResultO, e.rd, e.res);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    PipeValidW = 0; PipeRdW = 0; PipeResultW = 0;
    MduValid = 0; MduRd = 0; MduResult = 0;
    DivValid = 0; DivRd = 0; DivResult = 0;
    IssueValidE = 0; IssueRdE = 0;
    Rs1D = 5'd5; Rs2D = 5'd7;

    // reset state
    settle();
    chk("rst_regwrite", RegWriteO, 0);
    chk("rst_stall", StallPipe, 0);
    chk("rst_busy5", BusyRs1D, 0);
    tick();
    reset = 1'b0;

    // both units valid after reset: MDU first, then DIV
    MduValid = 1; MduRd = 5'd3; MduResult = 64'hA;
    DivValid = 1; DivRd = 5'd4; DivResult = 64'hB;
    push(5'd3, 64'hA);
    settle();
    chk("rr0_mdu_rdy", MduReady, 1);
    chk("rr0_div_rdy", DivReady, 0);
    tick();
    MduValid = 0;
    push(5'd4, 64'hB);
    settle();
    chk("rr1_div_rdy", DivReady, 1);
    chk("rr1_mdu_rdy", MduReady, 0);
    tick();
    DivValid = 0;

    // scoreboard set on issue, clear the cycle after grant
    IssueValidE = 1; IssueRdE = 5'd5; Rs1D = 5'd5;
    settle();
    chk("sb_c0", BusyRs1D, 0);
    tick();
    IssueValidE = 0;
    settle();
    chk("sb_c1", BusyRs1D, 1);
    tick();
    settle();
    chk("sb_c2", BusyRs1D, 1);
    tick();
    MduValid = 1; MduRd = 5'd5; MduResult = 64'hC;
    push(5'd5, 64'hC);
    settle();
    chk("sb_c3_rdy", MduReady, 1);
    chk("sb_c3_busy", BusyRs1D, 1);
    tick();
    MduValid = 0;
    settle();
    chk("sb_c4", BusyRs1D, 0);
    tick();

    // same-edge set and clear: set wins
    IssueValidE = 1; IssueRdE = 5'd7; Rs2D = 5'd7;
    tick();
    DivValid = 1; DivRd = 5'd7; DivResult = 64'hD;
    push(5'd7, 64'hD);
    settle();
    chk("sw_rdy", DivReady, 1);
    tick();
    IssueValidE = 0;
    DivResult = 64'hE;
    push(5'd7, 64'hE);
    settle();
    chk("sw_busy_kept", BusyRs2D, 1);
    tick();
    DivValid = 0;
    settle();
    chk("sw_busy_clr", BusyRs2D, 0);
    tick();

    // pipeline priority over a waiting MDU
    PipeValidW = 1;
    MduValid = 1; MduRd = 5'd11; MduResult = 64'hF;
`ifdef INTWB_STARVE_GUARD_EN
    for (int i = 0; i < 4; i++) begin
      PipeRdW = 5'(20 + i); PipeResultW = 64'(100 + i);
      push(PipeRdW, PipeResultW);
      settle();
      chk("sv_mdu_blocked", MduReady, 0);
      chk("sv_no_stall", StallPipe, 0);
      tick();
    end
    push(5'd11, 64'hF);
    settle();
    chk("sv_stall_set", StallPipe, 1);
    chk("sv_forced_rdy", MduReady, 1);
    tick();
    MduValid = 0;
    PipeRdW = 5'd24; PipeResultW = 64'd104;
    push(5'd24, 64'd104);
    settle();
    chk("sv_stall_clr", StallPipe, 0);
    tick();
    PipeValidW = 0;
`else
    for (int i = 0; i < 6; i++) begin
      PipeRdW = 5'(20 + i); PipeResultW = 64'(100 + i);
      push(PipeRdW, PipeResultW);
      settle();
      chk("pp_mdu_blocked", MduReady, 0);
      chk("pp_no_stall", StallPipe, 0);
      tick();
    end
    PipeValidW = 0;
    push(5'd11, 64'hF);
    settle();
    chk("pp_mdu_rdy", MduReady, 1);
    tick();
    MduValid = 0;
`endif

    // Rd=0 unit grant, and Rd=0 pipeline leaving the port free
    MduValid = 1; MduRd = 5'd0; MduResult = 64'h77;
    settle();
    chk("rd0_mdu_rdy", MduReady, 1);
    chk("rd0_no_write", RegWriteO, 0);
    tick();
    MduValid = 0;
    PipeValidW = 1; PipeRdW = 5'd0; PipeResultW = 64'h55;
    DivValid = 1; DivRd = 5'd12; DivResult = 64'h12;
    push(5'd12, 64'h12);
    settle();
    chk("p0_div_rdy", DivReady, 1);
    tick();
    PipeValidW = 0; DivValid = 0;

    // after an MDU grant, DIV wins the next tie
    MduValid = 1; MduRd = 5'd15; MduResult = 64'h15;
    push(5'd15, 64'h15);
    settle();
    chk("rr2_mdu_rdy", MduReady, 1);
    tick();
    MduRd = 5'd16; MduResult = 64'h16;
    DivValid = 1; DivRd = 5'd17; DivResult = 64'h17;
    push(5'd17, 64'h17);
    settle();
    chk("rr3_div_rdy", DivReady, 1);
    chk("rr3_mdu_rdy", MduReady, 0);
    tick();
    DivValid = 0;
    push(5'd16, 64'h16);
    settle();
    chk("rr4_mdu_rdy", MduReady, 1);
    tick();
    MduValid = 0;

    // async reset mid-handshake
    IssueValidE = 1; IssueRdE = 5'd9; Rs1D = 5'd9;
    tick();
    IssueValidE = 0;
    settle();
    chk("ar_busy9_set", BusyRs1D, 1);
    tick();
    DivValid = 1; DivRd = 5'd9; DivResult = 64'h99;
    reset = 1'b1;
    settle();
    chk("ar_div_rdy", DivReady, 0);
    chk("ar_regwrite", RegWriteO, 0);
    chk("ar_busy9_async", BusyRs1D, 0);
    tick();
    settle();
    chk("ar_div_rdy2", DivReady, 0);
    tick();
    reset = 1'b0;
    DivValid = 0;
    settle();
    chk("ar_busy9_after", BusyRs1D, 0);
    tick();
    MduValid = 1; MduRd = 5'd18; MduResult = 64'h18;
    DivValid = 1; DivRd = 5'd19; DivResult = 64'h19;
    push(5'd18, 64'h18);
    settle();
    chk("ar_rr_mdu", MduReady, 1);
    chk("ar_rr_div", DivReady, 0);
    tick();
    MduValid = 0;
    push(5'd19, 64'h19);
    settle();
    chk("ar_rr_div2", DivReady, 1);
    tick();
    DivValid = 0;

    settle();
    chk("exp_queue_empty", 64'(expq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
